// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-RAM controller: address map, defaults
// and the controller state encoding.
package imem_pkg;

    localparam int          IM_ADRBITS      = 12;
    localparam logic [31:0] IM_BASE         = 32'h0000_3000;
    localparam logic [31:0] IM_HANDLER_BASE = 32'h0000_4180;
    localparam int          IM_STARVE_MAX   = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } im_state_t;

    // Per-cycle arbitration outcome.
    typedef struct packed {
        logic fetch;
        logic ld;
    } im_grant_t;

endpackage

// File: rtl/imem_addr_chk.sv
// Byte address -> RAM word index plus legality flag (aligned and inside the
// DEPTH-word window starting at BASE). Purely combinational.
module imem_addr_chk
    import imem_pkg::*;
#(
    parameter int          ADRBITS = IM_ADRBITS,
    parameter logic [31:0] BASE    = IM_BASE
) (
    input  logic [31:0]        addr,
    output logic [ADRBITS-1:0] idx,
    output logic               ok
);

    logic [31:0] off;
    logic        unused_lo;

    // Subtraction wraps, so addresses below BASE land far above the window.
    assign off       = addr - BASE;
    assign idx       = off[ADRBITS+1:2];
    assign ok        = (addr[1:0] == 2'b00) && (off[31:ADRBITS+2] == '0);
    assign unused_lo = ^off[1:0];

endmodule

// File: rtl/imem_ctrl.sv
// Single-port instruction RAM controller: zero-fills the RAM after reset, then
// arbitrates each cycle between CPU fetch and the loader write port.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int          ADRBITS      = IM_ADRBITS,
    parameter logic [31:0] BASE         = IM_BASE,
    parameter int          STARVE_MAX   = IM_STARVE_MAX,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [31:0]        if_pc,
    output logic               if_stall,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic               if_adel,
    input  logic               ld_req,
    input  logic [31:0]        ld_addr,
    input  logic [31:0]        ld_wdata,
    output logic               ld_ack,
    output logic               ld_err,
    output logic               busy,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADRBITS-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam int                 SW       = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]      SMAX     = SW'(STARVE_MAX);
    localparam logic [ADRBITS-1:0] LAST_IDX = '1;

    im_state_t          state, nxt;
    logic [ADRBITS-1:0] clr_idx;
    logic [SW-1:0]      starve, starve_nxt;
    im_grant_t          gnt;

    logic [ADRBITS-1:0] f_idx, l_idx;
    logic               f_ok, l_ok;

    imem_addr_chk #(.ADRBITS(ADRBITS), .BASE(BASE)) u_fchk (
        .addr (if_pc),
        .idx  (f_idx),
        .ok   (f_ok)
    );

    imem_addr_chk #(.ADRBITS(ADRBITS), .BASE(BASE)) u_lchk (
        .addr (ld_addr),
        .idx  (l_idx),
        .ok   (l_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR_ON_RST ? ST_INIT : ST_RUN;
            clr_idx  <= '0;
            starve   <= '0;
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
        end else begin
            state    <= nxt;
            starve   <= starve_nxt;
            if_valid <= gnt.fetch;
            if_adel  <= gnt.fetch && !f_ok;
            if (state == ST_INIT)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    // Combinational outputs are held quiet while reset is asserted so the RAM
    // never sees an enable during reset.
    always_comb begin
        nxt        = state;
        starve_nxt = '0;
        gnt        = '0;
        busy       = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ld_ack     = 1'b0;
        ld_err     = 1'b0;

        case (state)
            ST_INIT: begin
                if (reset) begin
                    busy     = 1'b1;
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = clr_idx;
                    if (clr_idx == LAST_IDX)
                        nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reset) begin
                    // Loader has priority until fetch has been starved STARVE_MAX times.
                    if (if_req && (!ld_req || starve == SMAX))
                        gnt.fetch = 1'b1;
                    else if (ld_req)
                        gnt.ld = 1'b1;

                    if (if_req && !gnt.fetch)
                        starve_nxt = (starve == SMAX) ? SMAX : starve + 1'b1;

                    if (gnt.fetch && f_ok) begin
                        mem_en   = 1'b1;
                        mem_addr = f_idx;
                    end else if (gnt.ld) begin
                        ld_ack = 1'b1;
                        ld_err = !l_ok;
                        if (l_ok) begin
                            mem_en    = 1'b1;
                            mem_we    = 1'b1;
                            mem_addr  = l_idx;
                            mem_wdata = ld_wdata;
                        end
                    end
                end
            end
            default: nxt = ST_INIT;
        endcase
    end

    assign if_stall = if_req && !gnt.fetch && reset;
    // RAM read data is live in the response cycle; a loader write in that same
    // cycle only updates the array, not the already-registered read data.
    assign if_instr = (if_valid && !if_adel) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a behavioural synchronous RAM attached.
module tb_imem_ctrl;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_stall, if_valid, if_adel;
    logic [31:0] if_instr;
    logic        ld_req;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_ack, ld_err, busy;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [4096];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    imem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_pc     (if_pc),
        .if_stall  (if_stall),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_adel   (if_adel),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_ack    (ld_ack),
        .ld_err    (ld_err),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Releases reset and follows the zero-fill, expecting indices 0..4095 in order.
    task automatic run_clear(input string tag);
        int cnt = 0;
        int bad = 0;
        @(negedge clk); reset = 1'b1; #1;
        while (busy === 1'b1 && cnt < 5000) begin
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== cnt[11:0] || mem_wdata !== 32'h0)
                bad++;
            cnt++;
            @(negedge clk); #1;
        end
        chk({tag, "_len"}, cnt, 4096);
        chk({tag, "_seq"}, bad, 0);
        chk({tag, "_busy_lo"}, busy, 1'b0);
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp, input logic adel);
        @(negedge clk); if_req = 1'b1; if_pc = pc; #1;
        chk({tag, "_stall"}, if_stall, 1'b0);
        chk({tag, "_en"}, mem_en, !adel);
        @(negedge clk); if_req = 1'b0; #1;
        chk({tag, "_valid"}, if_valid, 1'b1);
        chk({tag, "_adel"}, if_adel, adel);
        chk({tag, "_instr"}, if_instr, exp);
    endtask

    task automatic ldw(input string tag, input logic [31:0] a, input logic [31:0] d, input logic err,
                       input logic [11:0] idx);
        @(negedge clk); ld_req = 1'b1; ld_addr = a; ld_wdata = d; #1;
        chk({tag, "_ack"}, ld_ack, 1'b1);
        chk({tag, "_err"}, ld_err, err);
        chk({tag, "_we"}, mem_we, !err);
        if (!err) chk({tag, "_idx"}, mem_addr, idx);
        @(negedge clk); ld_req = 1'b0;
    endtask

    initial begin
        logic [9:0] stall_v, ack_v;
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA5A5_0000 | i;
        reset = 1'b0; if_req = 1'b0; if_pc = '0; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;

        // 1: reset and clear
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_instr", if_instr, 32'h0);
        run_clear("clr1");
        chk("clr1_ram4095", ram[4095], 32'h0);
        fetch("f_zero", 32'h3000, 32'h0, 1'b0);

        // 2: write then read back
        ldw("ld0", 32'h3000, 32'h3C01_1234, 1'b0, 12'd0);
        fetch("f0", 32'h3000, 32'h3C01_1234, 1'b0);

        // 3: address errors and window edges
        fetch("f_mis", 32'h3002, 32'h0, 1'b1);
        fetch("f_low", 32'h2FFC, 32'h0, 1'b1);
        fetch("f_high", 32'h7000, 32'h0, 1'b1);
        fetch("f_top", 32'h6FFC, 32'h0, 1'b0);
        @(negedge clk); ld_req = 1'b1; ld_addr = 32'h7000; ld_wdata = 32'hFFFF_FFFF; #1;
        chk("ld_bad_ack", ld_ack, 1'b1);
        chk("ld_bad_err", ld_err, 1'b1);
        chk("ld_bad_en", mem_en, 1'b0);
        @(negedge clk); ld_req = 1'b0;
        chk("ld_bad_ram0", ram[0], 32'h3C01_1234);

        // 4: handler region
        ldw("ld_h", IM_HANDLER_BASE, 32'h4200_0018, 1'b0, 12'd1120);
        chk("ld_h_ram", ram[1120], 32'h4200_0018);
        fetch("f_h", 32'h4180, 32'h4200_0018, 1'b0);

        // 5: contention, loader writes 0x3100 with the cycle number
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_pc = 32'h3000;
            ld_req = 1'b1; ld_addr = 32'h3100; ld_wdata = 32'h100 + i;
            #1;
            stall_v[i] = if_stall;
            ack_v[i]   = ld_ack;
        end
        @(negedge clk); if_req = 1'b0; ld_req = 1'b0;
        chk("arb_stall", {22'h0, stall_v}, 32'h0000_01EF);
        chk("arb_ack", {22'h0, ack_v}, 32'h0000_01EF);
        fetch("f_arb", 32'h3100, 32'h0000_0108, 1'b0);

        // 6: reset mid-clear, then reset with a fetch outstanding
        ldw("ld_200", 32'h3320, 32'hCAFE_F00D, 1'b0, 12'd200);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        chk("mid_idx", mem_addr, 12'd100);
        reset = 1'b0; #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_en", mem_en, 1'b0);
        chk("mid_we", mem_we, 1'b0);
        repeat (2) @(negedge clk);
        run_clear("clr2");
        chk("clr2_ram200", ram[200], 32'h0);

        @(negedge clk); if_req = 1'b1; if_pc = 32'h3000; #1;
        chk("rst_f_grant", if_stall, 1'b0);
        reset = 1'b0;
        @(negedge clk); if_req = 1'b0; #1;
        chk("rst_f_valid", if_valid, 1'b0);
        chk("rst_f_instr", if_instr, 32'h0);
        run_clear("clr3");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
